draw_score_text: RTL and testbench

- VGA pipeline stage that overlays the line "YOUR SCORE: nnn" onto the incoming pixel stream.
- Sits directly upstream of score_writing: drives its char_yx and consumes its registered char_code. It also drives the font ROM address and consumes the ROM's pixel row.
- Appends the live score as three decimal digits. Binary-to-BCD conversion is iterative (double-dabble) and runs once per frame.

---
 rtl/draw_score_text.sv | 206 ++++++++++++++++++++
 tb/tb_draw_score_text.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_score_text.sv
// rtl/draw_score_text.sv - overlays "YOUR SCORE: nnn" onto the VGA pixel stream
module draw_score_text #(
    parameter logic [10:0] XPOS       = 11'd100,
    parameter logic [10:0] YPOS       = 11'd20,
    parameter logic [11:0] TEXT_COLOR = 12'hfff,
    parameter int          N_CHARS    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [9:0]  score,
    input  logic [7:0]  char_code,
    input  logic [7:0]  char_pixels,
    output logic [7:0]  char_yx,
    output logic [10:0] char_line_addr,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [10:0] X_END    = XPOS + 11'(8 * N_CHARS);
    localparam logic [10:0] Y_END    = YPOS + 11'd16;
    localparam logic [4:0]  COL_HUND = 5'(N_CHARS - 3);
    localparam logic [4:0]  COL_TENS = 5'(N_CHARS - 2);
    localparam logic [4:0]  COL_UNIT = 5'(N_CHARS - 1);

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } timing_t;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

    timing_t     t1, t2, t3;
    logic        box_1, box_2, box_3;
    logic [4:0]  col_1, col_2;
    logic [3:0]  line_1, line_2;
    logic [2:0]  xoff_1, xoff_2, xoff_3;
    logic [10:0] hrel, vrel;
    logic        box_now;
    logic [7:0]  code_2;
    logic        pix;

    conv_state_t state;
    logic        vsync_prev;
    logic [9:0]  bin;
    logic [11:0] bcd;
    logic [11:0] adj;
    logic [3:0]  bit_cnt;
    logic [11:0] digits;
    logic        hund_blank, tens_blank;
    logic        unused_bits;

    // Unsigned compares: pixels left of XPOS never wrap into the box.
    assign hrel    = hcount_in - XPOS;
    assign vrel    = vcount_in - YPOS;
    assign box_now = (hcount_in >= XPOS) && (hcount_in < X_END) &&
                     (vcount_in >= YPOS) && (vcount_in < Y_END);

    assign char_yx        = {3'b000, col_1};
    assign char_line_addr = {code_2[6:0], line_2};
    assign pix            = char_pixels[3'd7 - xoff_3];

    assign hund_blank  = (digits[11:8] == 4'd0);
    assign tens_blank  = hund_blank && (digits[7:4] == 4'd0);
    assign unused_bits = ^{hrel[10:8], vrel[10:4], code_2[7], adj[11]};

    // T1: locate the pixel inside the text box and register the timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t1     <= '0;
            box_1  <= 1'b0;
            col_1  <= 5'd0;
            line_1 <= 4'd0;
            xoff_1 <= 3'd0;
        end else begin
            t1     <= '{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
            box_1  <= box_now;
            col_1  <= box_now ? hrel[7:3] : 5'd0;
            line_1 <= vrel[3:0];
            xoff_1 <= hrel[2:0];
        end
    end

    // T2: score columns replace score_writing's code with blanked digits.
    always_comb begin
        code_2 = char_code;
        if (col_2 == COL_HUND) begin
            code_2 = hund_blank ? 8'h00 : 8'h30 + {4'd0, digits[11:8]};
        end else if (col_2 == COL_TENS) begin
            code_2 = tens_blank ? 8'h00 : 8'h30 + {4'd0, digits[7:4]};
        end else if (col_2 == COL_UNIT) begin
            code_2 = 8'h30 + {4'd0, digits[3:0]};
        end
    end

    // T2/T3 registers: carry position and timing while code and ROM row arrive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t2     <= '0;
            t3     <= '0;
            box_2  <= 1'b0;
            box_3  <= 1'b0;
            col_2  <= 5'd0;
            line_2 <= 4'd0;
            xoff_2 <= 3'd0;
            xoff_3 <= 3'd0;
        end else begin
            t2     <= t1;
            t3     <= t2;
            box_2  <= box_1;
            box_3  <= box_2;
            col_2  <= col_1;
            line_2 <= line_1;
            xoff_2 <= xoff_1;
            xoff_3 <= xoff_2;
        end
    end

    // T4: composite the glyph pixel over the background, outside blanking only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= t3.hc;
            vcount_out <= t3.vc;
            hsync_out  <= t3.hs;
            vsync_out  <= t3.vs;
            hblnk_out  <= t3.hb;
            vblnk_out  <= t3.vb;
            rgb_out    <= (box_3 && pix && !t3.hb && !t3.vb) ? TEXT_COLOR : t3.rgb;
        end
    end

    // Double-dabble correction: add 3 to each BCD nibble of 5 or more before shifting.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Once-per-frame converter; digits update only in DONE so a frame never shows a partial value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vsync_prev <= 1'b0;
            bin        <= 10'd0;
            bcd        <= 12'd0;
            bit_cnt    <= 4'd0;
            digits     <= 12'd0;
        end else begin
            vsync_prev <= vsync_in;
            case (state)
                IDLE: begin
                    if (vsync_in && !vsync_prev) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bin     <= (score > 10'd999) ? 10'd999 : score;
                    bcd     <= 12'd0;
                    bit_cnt <= 4'd0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    bcd     <= {adj[10:0], bin[9]};
                    bin     <= {bin[8:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    digits <= bcd;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_score_text.sv
// tb/tb_draw_score_text.sv - self-checking bench for draw_score_text
module tb_draw_score_text;

    localparam int XP = 100;
    localparam int YP = 20;
    localparam int NC = 17;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [9:0]  score;
    logic [7:0]  char_code;
    logic [7:0]  char_pixels;
    logic [7:0]  char_yx;
    logic [10:0] char_line_addr;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [10:0] hc;
        logic [10:0] vc;
        logic [3:0]  sync;
        logic [11:0] rgb;
    } exp_t;

    exp_t       q[$];
    int         dh, dt, du;
    logic [7:0] tbl [0:31];
    logic       ovr_en;
    logic [7:0] ovr_val;

    always #5 clk = ~clk;

    draw_score_text dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .hblnk_in       (hblnk_in),
        .vblnk_in       (vblnk_in),
        .rgb_in         (rgb_in),
        .score          (score),
        .char_code      (char_code),
        .char_pixels    (char_pixels),
        .char_yx        (char_yx),
        .char_line_addr (char_line_addr),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .hblnk_out      (hblnk_out),
        .vblnk_out      (vblnk_out),
        .rgb_out        (rgb_out)
    );

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        logic [15:0] t;
        t = {5'd0, a} * 16'd157 + 16'h005a;
        return t[11:4] ^ a[7:0];
    endfunction

    // score_writing stand-in: registered text lookup
    always @(posedge clk) begin
        if (!rst_n) char_code <= 8'h00;
        else        char_code <= tbl[char_yx[4:0]];
    end

    // font ROM stand-in: registered row lookup
    always @(posedge clk) begin
        char_pixels <= ovr_en ? ovr_val : font_fn(char_line_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] digit_code(input int col);
        if (col == NC - 3) return (dh == 0) ? 8'h00 : 8'(48 + dh);
        if (col == NC - 2) return (dh == 0 && dt == 0) ? 8'h00 : 8'(48 + dt);
        return 8'(48 + du);
    endfunction

    function automatic logic [11:0] model_rgb(input int h, input int v, input logic hb,
                                              input logic vb, input logic [11:0] rgb);
        int col, line, xo;
        logic [7:0] code, row;
        if (hb || vb || h < XP || h >= XP + 8 * NC || v < YP || v >= YP + 16) return rgb;
        col  = (h - XP) / 8;
        line = v - YP;
        xo   = (h - XP) % 8;
        code = (col < NC - 3) ? tbl[col] : digit_code(col);
        row  = ovr_en ? ovr_val : font_fn({code[6:0], 4'(line)});
        return row[7 - xo] ? 12'hfff : rgb;
    endfunction

    task automatic step(input int h, input int v, input logic hs, input logic vs,
                        input logic hb, input logic vb, input logic [11:0] rgb);
        exp_t e;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        e.hc   = 11'(h);
        e.vc   = 11'(v);
        e.sync = {hs, vs, hb, vb};
        e.rgb  = model_rgb(h, v, hb, vb, rgb);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 4) begin
            e = q.pop_front();
            check("rgb_out", 32'(rgb_out), 32'(e.rgb));
            check("hcount_out", 32'(hcount_out), 32'(e.hc));
            check("vcount_out", 32'(vcount_out), 32'(e.vc));
            check("sync_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(e.sync));
        end
    endtask

    task automatic set_model_digits(input int s);
        int c;
        c  = (s > 999) ? 999 : s;
        dh = c / 100;
        dt = (c / 10) % 10;
        du = c % 10;
    endtask

    task automatic convert(input int s);
        score = 10'(s);
        step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h00f);
        repeat (16) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00f);
        set_model_digits(s);
    endtask

    task automatic check_cols(input logic [7:0] c14, input logic [7:0] c15, input logic [7:0] c16);
        step(XP + 8 * 14, YP + 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
        step(XP + 8 * 15, YP + 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
        check("col14_addr", 32'(char_line_addr), 32'({c14[6:0], 4'd5}));
        step(XP + 8 * 16, YP + 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
        check("col15_addr", 32'(char_line_addr), 32'({c15[6:0], 4'd5}));
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
        check("col16_addr", 32'(char_line_addr), 32'({c16[6:0], 4'd5}));
    endtask

    initial begin
        string txt;
        int s;
        txt = "YOUR SCORE:      ";
        for (int i = 0; i < 32; i++) tbl[i] = 8'h3f;
        for (int i = 0; i < NC; i++) tbl[i] = txt[i];
        ovr_en  = 1'b0;
        ovr_val = 8'h00;
        dh = 0; dt = 0; du = 0;

        // reset with active inputs
        rst_n     = 1'b0;
        hcount_in = 11'd50;
        vcount_in = 11'd40;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        hblnk_in  = 1'b1;
        vblnk_in  = 1'b1;
        rgb_in    = 12'hfff;
        score     = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", 32'(rgb_out), 32'd0);
        check("rst_hcount", 32'(hcount_out), 32'd0);
        check("rst_vcount", 32'(vcount_out), 32'd0);
        check("rst_sync", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
        check("rst_char_yx", 32'(char_yx), 32'd0);
        check("rst_addr", 32'(char_line_addr), 32'd0);
        rst_n = 1'b1;

        // pass-through outside the box, exactly 4 cycles
        step(5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0a0);
        repeat (3) step(7, 9, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123);
        check("pass_rgb", 32'(rgb_out), 32'h0a0);
        check("pass_hsync", 32'(hsync_out), 32'd1);
        step(7, 9, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123);
        check("pass_rgb_next", 32'(rgb_out), 32'h123);

        // text pixel at col 2, line 3, xoff 0
        tbl[2]  = 8'h59;
        ovr_en  = 1'b1;
        ovr_val = 8'h80;
        step(XP + 16, YP + 3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
        check("text_char_yx", 32'(char_yx), 32'h02);
        step(XP + 16, YP + 3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
        check("text_addr", 32'(char_line_addr), 32'h593);
        step(XP + 17, YP + 3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
        step(XP + 17, YP + 3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
        check("text_rgb", 32'(rgb_out), 32'hfff);
        step(XP - 1, YP, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
        step(XP + 8 * NC, YP, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
        step(XP, YP + 16, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
        ovr_en = 1'b0;
        tbl[2] = txt[2];

        // conversions, blanking and saturation
        convert(257);
        check_cols(8'h32, 8'h35, 8'h37);
        convert(7);
        check_cols(8'h00, 8'h00, 8'h37);
        convert(1023);
        check_cols(8'h39, 8'h39, 8'h39);
        convert(40);
        check_cols(8'h00, 8'h34, 8'h30);

        // score change and second vsync edge while converting
        score = 10'd123;
        step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h00f);
        repeat (4) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00f);
        score = 10'd456;
        step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h00f);
        repeat (14) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00f);
        set_model_digits(123);
        check_cols(8'h31, 8'h32, 8'h33);

        // reset during SHIFT aborts conversion and clears digits
        score = 10'd888;
        step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h00f);
        repeat (4) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00f);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        rst_n = 1'b1;
        set_model_digits(0);
        repeat (16) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00f);
        check_cols(8'h00, 8'h00, 8'h30);

        // randomized frames against the model
        repeat (6) begin
            s = int'($urandom_range(0, 1023));
            convert(s);
            check_cols(digit_code(14), digit_code(15), digit_code(16));
            repeat (60) begin
                step(int'($urandom_range(XP - 10, XP + 8 * NC + 10)),
                     int'($urandom_range(YP - 3, YP + 18)),
                     1'($urandom), 1'b0,
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                     12'($urandom));
            end
        end
        repeat (4) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
